// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath types plus icache frame, address-split and FSM state types
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  localparam int ICACHE_SETS = 16;
  localparam int ICACHE_IDX_W = 4;
  localparam int ICACHE_TAG_W = 32 - ICACHE_IDX_W - 2;
  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0] bytoff;
  } icachef_t;
  typedef struct packed {
    logic valid;
    logic [ICACHE_TAG_W-1:0] tag;
    word_t data;
  } icache_frame_t;
  typedef enum logic {IDLE, FETCH} icache_state_t;
endpackage

// File: rtl/icache_if.sv
// icache_if: fetch-port and memory-port signals between datapath, icache and memory controller
// imemREN/imemaddr: fetch request; ihit/imemload: fetch response
// iREN/iaddr: memory read request; iwait/iload: memory response
interface icache_if;
  import cpu_types_pkg::*;
  logic imemREN;
  word_t imemaddr;
  logic ihit;
  word_t imemload;
  logic iREN;
  word_t iaddr;
  logic iwait;
  word_t iload;
  modport slave (input imemREN, imemaddr, iwait, iload, output ihit, imemload, iREN, iaddr);
  modport master (output imemREN, imemaddr, iwait, iload, input ihit, imemload, iREN, iaddr);
endinterface

// File: rtl/icache_frames.sv
// icache_frames: direct-mapped frame array, combinational read by index, synchronous fill write
// CLK/RST: clock and synchronous clear; rd_*: lookup port; we/wr_*: fill port
module icache_frames
  import cpu_types_pkg::*;
#(
  parameter int SETS = 16,
  localparam int IDX_W = $clog2(SETS),
  localparam int TAG_W = 30 - IDX_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output word_t            rd_data,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  word_t            wr_data
);
  typedef struct packed {
    logic valid;
    logic [TAG_W-1:0] tag;
    word_t data;
  } frame_t;
  frame_t frames_q [SETS];
  frame_t frames_d [SETS];
  always_comb begin
    frames_d = frames_q;
    if (we) frames_d[wr_idx] = '{valid: 1'b1, tag: wr_tag, data: wr_data};
    rd_valid = frames_q[rd_idx].valid;
    rd_tag = frames_q[rd_idx].tag;
    rd_data = frames_q[rd_idx].data;
  end
  always_ff @(posedge CLK) begin
    if (RST) frames_q <= '{default: '0};
    else frames_q <= frames_d;
  end
endmodule

// File: rtl/icache.sv
// icache: direct-mapped one-word-block instruction cache with single-word miss fill
// CLK/RST: clock and synchronous active-high reset; bus: fetch and memory handshake
// hit_count: saturating count of ihit cycles; miss_count: saturating count of fills started
module icache
  import cpu_types_pkg::*;
#(
  parameter int SETS = 16,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  icache_if.slave          bus,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;
  icache_state_t state_q, state_d;
  word_t miss_addr_q, miss_addr_d;
  logic [CNT_W-1:0] hit_q, hit_d, miss_q, miss_d;
  logic rd_valid, hit, miss, fill;
  logic [TAG_W-1:0] rd_tag;
  word_t rd_data;
  logic unused_bytoff;
  assign unused_bytoff = ^bus.imemaddr[1:0];
  icache_frames #(.SETS(SETS)) u_frames (
    .CLK     (CLK),
    .RST     (RST),
    .rd_idx  (bus.imemaddr[IDX_W+1:2]),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .we      (fill),
    .wr_idx  (miss_addr_q[IDX_W+1:2]),
    .wr_tag  (miss_addr_q[31:IDX_W+2]),
    .wr_data (bus.iload)
  );
  always_comb begin
    hit = state_q == IDLE && bus.imemREN && rd_valid && rd_tag == bus.imemaddr[31:IDX_W+2];
    miss = state_q == IDLE && bus.imemREN && !hit;
    fill = state_q == FETCH && !bus.iwait;
    state_d = miss ? FETCH : fill ? IDLE : state_q;
    miss_addr_d = miss ? {bus.imemaddr[31:2], 2'b00} : miss_addr_q;
    hit_d = hit_q + CNT_W'(hit && !(&hit_q));
    miss_d = miss_q + CNT_W'(miss && !(&miss_q));
    bus.ihit = hit;
    bus.imemload = hit ? rd_data : '0;
    bus.iREN = state_q == FETCH;
    bus.iaddr = state_q == FETCH ? miss_addr_q : '0;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      miss_addr_q <= '0;
      hit_q <= '0;
      miss_q <= '0;
    end else begin
      state_q <= state_d;
      miss_addr_q <= miss_addr_d;
      hit_q <= hit_d;
      miss_q <= miss_d;
    end
  end
  assign hit_count = hit_q;
  assign miss_count = miss_q;
endmodule

// File: tb/tb_icache.sv
// tb_icache: scoreboard bench for icache fetch hits, fills, conflicts, reset abort and counter saturation
module tb_icache;
  import cpu_types_pkg::*;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;
  icache_if bus ();
  icache_if bus4 ();
  logic [31:0] hit_count, miss_count;
  logic [3:0] hit_count4, miss_count4;
  icache dut (.CLK(CLK), .RST(RST), .bus(bus.slave), .hit_count(hit_count), .miss_count(miss_count));
  icache #(.CNT_W(4)) dut4 (.CLK(CLK), .RST(RST), .bus(bus4.slave), .hit_count(hit_count4), .miss_count(miss_count4));
  int vectors = 0;
  int miscompares = 0;
  word_t exp_q [$];
  word_t mem [word_t];
  int mem_wait = 0;
  int wcnt = 0;
  always @(negedge CLK) begin
    if (bus.iREN) begin
      if (wcnt >= mem_wait) begin
        bus.iwait = 1'b0;
        bus.iload = mem.exists(bus.iaddr) ? mem[bus.iaddr] : 32'h0;
        wcnt = 0;
      end else begin
        bus.iwait = 1'b1;
        bus.iload = 32'h0;
        wcnt++;
      end
    end else begin
      bus.iwait = 1'b1;
      bus.iload = 32'h0;
      wcnt = 0;
    end
  end
  task automatic test_reset;
    bus.imemREN = 1'b0;
    bus.imemaddr = 32'h0;
    bus4.imemREN = 1'b0;
    bus4.imemaddr = 32'h0;
    bus4.iwait = 1'b0;
    bus4.iload = 32'hCAFEF00D;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 bus.imemREN = 1'b1;
    bus.imemaddr = 32'h40;
    @(negedge CLK);
    vectors++;
    if (bus.ihit !== 1'b0 || bus.imemload !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_resp: ihit=%b imemload=%h want 0/0", bus.ihit, bus.imemload);
    end
    vectors++;
    if (bus.iREN !== 1'b0 || bus.iaddr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mem: iREN=%b iaddr=%h want 0/0", bus.iREN, bus.iaddr);
    end
    vectors++;
    if (hit_count !== 32'h0 || miss_count !== 32'h0 || miss_count4 !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_cnt: hit=%0d miss=%0d miss4=%0d want 0", hit_count, miss_count, miss_count4);
    end
    @(posedge CLK);
    #1 RST = 1'b0;
    bus.imemREN = 1'b0;
  endtask
  task automatic test_cold_miss;
    mem[32'h40] = 32'hDEADBEEF;
    mem_wait = 2;
    @(posedge CLK);
    #1 bus.imemREN = 1'b1;
    bus.imemaddr = 32'h40;
    exp_q.push_back(32'hDEADBEEF);
    @(negedge CLK);
    vectors++;
    if (bus.ihit !== 1'b0 || bus.iREN !== 1'b0) begin
      miscompares++;
      $display("FAIL cold_lookup: ihit=%b iREN=%b want 0/0", bus.ihit, bus.iREN);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      vectors++;
      if (bus.iREN !== 1'b1 || bus.iaddr !== 32'h40 || bus.ihit !== 1'b0) begin
        miscompares++;
        $display("FAIL cold_fetch%0d: iREN=%b iaddr=%h ihit=%b want 1/00000040/0", i, bus.iREN, bus.iaddr, bus.ihit);
      end
    end
    @(negedge CLK);
    vectors++;
    if (bus.ihit !== 1'b1 || exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL cold_hit: ihit=%b want 1", bus.ihit);
    end else begin
      word_t e = exp_q.pop_front();
      vectors++;
      if (bus.imemload !== e) begin
        miscompares++;
        $display("FAIL cold_data: imemload=%h want %h", bus.imemload, e);
      end
    end
    vectors++;
    if (miss_count !== 32'd1 || hit_count !== 32'd0) begin
      miscompares++;
      $display("FAIL cold_cnt: miss=%0d hit=%0d want 1/0", miss_count, hit_count);
    end
    @(negedge CLK);
    vectors++;
    if (hit_count !== 32'd1) begin
      miscompares++;
      $display("FAIL cold_hitcnt: hit=%0d want 1", hit_count);
    end
  endtask
  task automatic test_hits;
    word_t addrs [4] = '{32'h40, 32'h43, 32'h41, 32'h42};
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK);
      #1 bus.imemaddr = addrs[i];
      exp_q.push_back(32'hDEADBEEF);
      @(negedge CLK);
      vectors++;
      if (bus.ihit !== 1'b1 || bus.iREN !== 1'b0 || exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL hit%0d: ihit=%b iREN=%b want 1/0", i, bus.ihit, bus.iREN);
      end else begin
        word_t e = exp_q.pop_front();
        vectors++;
        if (bus.imemload !== e) begin
          miscompares++;
          $display("FAIL hit%0d_data: imemload=%h want %h", i, bus.imemload, e);
        end
      end
      vectors++;
      if (hit_count !== 32'(2 + i)) begin
        miscompares++;
        $display("FAIL hit%0d_cnt: hit=%0d want %0d", i, hit_count, 2 + i);
      end
    end
  endtask
  task automatic fill_wait(input string name, input int want_miss);
    int c = 0;
    while (!bus.ihit && c < 20) begin
      @(negedge CLK);
      c++;
    end
    vectors++;
    if (bus.ihit !== 1'b1 || exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s_timeout: ihit=%b after %0d cycles want 1", name, bus.ihit, c);
    end else begin
      word_t e = exp_q.pop_front();
      vectors++;
      if (bus.imemload !== e) begin
        miscompares++;
        $display("FAIL %s_data: imemload=%h want %h", name, bus.imemload, e);
      end
    end
    vectors++;
    if (miss_count !== 32'(want_miss)) begin
      miscompares++;
      $display("FAIL %s_misscnt: miss=%0d want %0d", name, miss_count, want_miss);
    end
  endtask
  task automatic test_conflict;
    mem[32'h80] = 32'h12345678;
    mem_wait = 0;
    @(posedge CLK);
    #1 bus.imemaddr = 32'h80;
    exp_q.push_back(32'h12345678);
    @(negedge CLK);
    vectors++;
    if (bus.ihit !== 1'b0) begin
      miscompares++;
      $display("FAIL conflict_80: ihit=%b want 0", bus.ihit);
    end
    fill_wait("conflict_80", 2);
    @(posedge CLK);
    #1 bus.imemaddr = 32'h40;
    exp_q.push_back(32'hDEADBEEF);
    @(negedge CLK);
    vectors++;
    if (bus.ihit !== 1'b0) begin
      miscompares++;
      $display("FAIL conflict_40: ihit=%b want 0", bus.ihit);
    end
    fill_wait("conflict_40", 3);
  endtask
  task automatic test_addr_change;
    mem[32'h44] = 32'hA1A1A1A1;
    mem[32'h48] = 32'hA2A2A2A2;
    mem_wait = 1;
    @(posedge CLK);
    #1 bus.imemaddr = 32'h44;
    @(negedge CLK);
    @(posedge CLK);
    #1 bus.imemaddr = 32'h48;
    exp_q.push_back(32'hA2A2A2A2);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      vectors++;
      if (bus.iREN !== 1'b1 || bus.iaddr !== 32'h44) begin
        miscompares++;
        $display("FAIL chg_fetch%0d: iREN=%b iaddr=%h want 1/00000044", i, bus.iREN, bus.iaddr);
      end
    end
    @(negedge CLK);
    vectors++;
    if (bus.ihit !== 1'b0 || bus.iREN !== 1'b0) begin
      miscompares++;
      $display("FAIL chg_relookup: ihit=%b iREN=%b want 0/0", bus.ihit, bus.iREN);
    end
    @(negedge CLK);
    vectors++;
    if (bus.iREN !== 1'b1 || bus.iaddr !== 32'h48) begin
      miscompares++;
      $display("FAIL chg_fetch48: iREN=%b iaddr=%h want 1/00000048", bus.iREN, bus.iaddr);
    end
    fill_wait("chg_48", 5);
    @(posedge CLK);
    #1 bus.imemaddr = 32'h44;
    exp_q.push_back(32'hA1A1A1A1);
    @(negedge CLK);
    fill_wait("chg_44", 5);
  endtask
  task automatic test_reset_fetch;
    mem[32'h4C] = 32'hB4B4B4B4;
    mem_wait = 3;
    @(posedge CLK);
    #1 bus.imemaddr = 32'h4C;
    @(negedge CLK);
    @(negedge CLK);
    vectors++;
    if (bus.iREN !== 1'b1 || bus.iaddr !== 32'h4C) begin
      miscompares++;
      $display("FAIL rstf_fetch: iREN=%b iaddr=%h want 1/0000004c", bus.iREN, bus.iaddr);
    end
    @(posedge CLK);
    #1 RST = 1'b1;
    bus.imemREN = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    vectors++;
    if (bus.iREN !== 1'b0 || bus.iaddr !== 32'h0) begin
      miscompares++;
      $display("FAIL rstf_iren: iREN=%b iaddr=%h want 0/0", bus.iREN, bus.iaddr);
    end
    vectors++;
    if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
      miscompares++;
      $display("FAIL rstf_cnt: hit=%0d miss=%0d want 0/0", hit_count, miss_count);
    end
    @(posedge CLK);
    #1 RST = 1'b0;
    bus.imemREN = 1'b1;
    bus.imemaddr = 32'h40;
    mem_wait = 0;
    exp_q.push_back(32'hDEADBEEF);
    @(negedge CLK);
    vectors++;
    if (bus.ihit !== 1'b0) begin
      miscompares++;
      $display("FAIL rstf_40: ihit=%b want 0", bus.ihit);
    end
    fill_wait("rstf_40", 1);
    @(posedge CLK);
    #1 bus.imemREN = 1'b0;
  endtask
  task automatic test_saturate;
    int c = 0;
    @(posedge CLK);
    #1 bus4.imemREN = 1'b1;
    bus4.imemaddr = 32'h10;
    exp_q.push_back(32'hCAFEF00D);
    @(negedge CLK);
    while (!bus4.ihit && c < 20) begin
      @(negedge CLK);
      c++;
    end
    vectors++;
    if (bus4.ihit !== 1'b1 || exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL sat_timeout: ihit=%b after %0d cycles want 1", bus4.ihit, c);
    end else begin
      word_t e = exp_q.pop_front();
      vectors++;
      if (bus4.imemload !== e) begin
        miscompares++;
        $display("FAIL sat_data: imemload=%h want %h", bus4.imemload, e);
      end
    end
    repeat (20) @(negedge CLK);
    vectors++;
    if (hit_count4 !== 4'hF || miss_count4 !== 4'd1) begin
      miscompares++;
      $display("FAIL sat_cnt: hit4=%h miss4=%h want f/1", hit_count4, miss_count4);
    end
    vectors++;
    if (bus.ihit !== 1'b0 || miss_count !== 32'd1) begin
      miscompares++;
      $display("FAIL idle_noreq: ihit=%b miss=%0d want 0/1", bus.ihit, miss_count);
    end
  endtask
  initial begin
    test_reset();
    test_cold_miss();
    test_hits();
    test_conflict();
    test_addr_change();
    test_reset_fetch();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, one-word-per-block instruction cache; the responder for the datapath's instruction-fetch port (imemREN/imemaddr in, ihit/imemload out).
- Sits between datapath and memory controller.
- On miss, runs a single-word fill over the iREN/iaddr/iwait/iload memory handshake, then services the retried request.
- Exposes saturating hit/miss counters for performance measurement.

Parameters:
SETS, 16, number of frames; power of two, >= 2; IDX_W = log2(SETS) derived locally.
CNT_W, 32, width of hit_count/miss_count.

Ports:
CLK  in  1  clock; one clock for the whole block.
RST  in  1  reset; synchronous, active-high.
imemREN  in  1  datapath fetch request.
imemaddr  in  32  fetch byte address (word_t); bits [1:0] ignored.
ihit  out  1  request satisfied this cycle.
imemload  out  32  instruction word; valid when ihit=1.
iREN  out  1  memory read request.
iaddr  out  32  memory word address; bits [1:0] always 0.
iwait  in  1  memory busy; iload valid in a cycle with iREN=1 and iwait=0.
iload  in  32  memory read data.
hit_count  out  CNT_W  cycles with ihit=1.
miss_count  out  CNT_W  fills started.

Behaviour:
- Address split: offset [1:0], index [IDX_W+1:2], tag [31:IDX_W+2].
- Storage per frame: valid, tag, data.
- States: IDLE, FETCH.
- Reset (RST high at a CLK edge):
  - state <- IDLE; all valid, tag, data cleared to 0; miss_addr <- 0; both counters <- 0.
  - After that edge: ihit=0, imemload=0, iREN=0, iaddr=0.
- IDLE:
  - ihit = imemREN && valid[idx] && tag[idx]==tag(imemaddr), combinational, same cycle.
  - imemload = data[idx] when ihit, else 0.
  - iREN=0, iaddr=0.
  - Miss (imemREN=1, ihit=0): miss_addr <- {imemaddr[31:2],2'b00}; state <- FETCH; miss_count++.
- FETCH:
  - iREN=1, iaddr=miss_addr, ihit=0, imemload=0.
  - While iwait=1: hold state.
  - When iwait=0: frame[idx(miss_addr)] <- valid=1, tag(miss_addr), iload; state <- IDLE.
- Latency:
  - Hit: 0 cycles.
  - Miss: 1 (IDLE->FETCH) + memory cycles until iwait=0 + 1; ihit rises in IDLE on the cycle after the fill edge.
  - No data forwarding from iload.
- imemREN dropped or imemaddr changed during FETCH: fill completes with miss_addr regardless; the new address is looked up in IDLE afterwards.
- Conflict miss overwrites the resident frame unconditionally; no write-back (read-only cache).
- Counters:
  - hit_count increments every cycle ihit=1, including the post-fill hit.
  - miss_count increments on each IDLE->FETCH transition.
  - Both saturate at all-ones.
- RST during FETCH: aborts the fill; iREN low after that edge; frame not written; any memory response is ignored.
- imemREN=0 in IDLE: no state change, no counter change.

Decomposition:
- cpu_types_pkg gains: word_t (existing); icache_frame_t struct {valid, tag, data}; icachef_t address-split struct (tag/idx/bytoff) at the default SETS; enum icache_state_t {IDLE, FETCH}.
- One natural sub-module, icache_frames: frame array with one combinational read port (index) and one synchronous write port (fill), synchronous clear on RST.
- FSM and counters stay in icache.

Test Plan:
1. Reset, imemREN=1, imemaddr=0x00000040; memory holds iwait=1 for 2 FETCH cycles, then iwait=0, iload=0xDEADBEEF -> iREN=1, iaddr=0x40 for 3 cycles; ihit=1, imemload=0xDEADBEEF next cycle; miss_count=1, hit_count=1.
2. Continue requesting 0x40, then 0x43 -> ihit=1 same cycle, imemload=0xDEADBEEF, iREN stays 0; hit_count advances 1 per cycle.
3. Conflict: request 0x80 (index 0, same as 0x40) with iload=0x12345678 -> fill replaces frame 0; a following request for 0x40 misses (miss_count=3) and refetches.
4. Request 0x44 (miss), switch imemaddr to 0x48 during FETCH -> iaddr stays 0x44, set 1 filled; 0x48 then misses, iaddr=0x48.
5. RST high during FETCH for 0x4C -> iREN=0 and counters 0 after the edge; re-request 0x40 misses despite an earlier fill.
6. Force hit_count to all-ones (CNT_W=4 build, 16+ hit cycles) -> stays 4'hF.
